// File: rtl/tug_pkg.sv
// tug_pkg: shared state, winner codes and LFSR constants for the tug-of-war referee.
package tug_pkg;
    typedef enum logic [1:0] {CLR, PLAY, WIN, OVER} state_e;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b10;
    localparam logic [1:0] WIN_R    = 2'b01;
    // x^10 + x^7 + 1: bits 9 and 6 feed back, maximal length so the register never clears
    localparam logic [9:0] LFSR_TAPS = 10'b10_0100_0000;
    localparam logic [9:0] LFSR_SEED = '1;
endpackage

// File: rtl/tug_lfsr.sv
// tug_lfsr: Fibonacci LFSR shifting toward the MSB, feedback is the XOR of the tapped bits.
module tug_lfsr import tug_pkg::*; #(
    parameter int           W    = 10,
    parameter logic [W-1:0] TAPS = W'(LFSR_TAPS),
    parameter logic [W-1:0] SEED = W'(LFSR_SEED)
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q, q_d;
    always_comb q_d = en_i ? {q_q[W-2:0], ^(q_q & TAPS)} : q_q;
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) q_q <= SEED;
        else         q_q <= q_d;
    assign q_o = q_q;
endmodule

// File: rtl/tug_referee.sv
// tug_referee: turns player/computer presses into chain pulls, detects edge wins,
// keeps score and sequences round reset, winner hold and game over.
module tug_referee import tug_pkg::*; #(
    parameter int NUM_LIGHTS  = 9,
    parameter int SCORE_W     = 3,
    parameter int LFSR_W      = 10,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  key_player_i,
    input  logic [LFSR_W-1:0]     cpu_thresh_i,
    input  logic [NUM_LIGHTS-1:0] lights_i,
    output logic                  pull_l_o,
    output logic                  pull_r_o,
    output logic                  round_reset_o,
    output logic [1:0]            winner_o,
    output logic [SCORE_W-1:0]    score_l_o,
    output logic [SCORE_W-1:0]    score_r_o,
    output logic                  game_over_o
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_e               state_q, state_d;
    logic                 key_q, cpu_q;
    logic                 pull_l_q, pull_l_d, pull_r_q, pull_r_d;
    logic [1:0]           winner_q, winner_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d, score_r_q, score_r_d;
    logic [SCORE_W-1:0]   score_l_inc, score_r_inc;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [LFSR_W-1:0]    lfsr;
    logic                 cpu_lvl, press_l, press_r;
    logic                 lights_unused;

    // only the edge lights matter; the chain itself guarantees the rest
    assign lights_unused = ^lights_i[NUM_LIGHTS-2:1];

    tug_lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_W'(LFSR_TAPS)),
        .SEED (LFSR_W'(LFSR_SEED))
    ) u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (1'b1),
        .q_o     (lfsr)
    );

    always_comb begin
        cpu_lvl     = lfsr < cpu_thresh_i;
        press_l     = key_player_i & ~key_q;
        press_r     = cpu_lvl & ~cpu_q;
        score_l_inc = (score_l_q == SCORE_MAX) ? SCORE_MAX : score_l_q + 1'b1;
        score_r_inc = (score_r_q == SCORE_MAX) ? SCORE_MAX : score_r_q + 1'b1;
        state_d     = state_q;
        pull_l_d    = 1'b0;
        pull_r_d    = 1'b0;
        winner_d    = winner_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        hold_d      = hold_q;
        case (state_q)
            CLR: begin
                state_d  = PLAY;
                winner_d = WIN_NONE;
                hold_d   = '0;
            end
            PLAY: begin
                // simultaneous presses cancel out
                if (press_l && !press_r) begin
                    if (lights_i[NUM_LIGHTS-1]) begin
                        winner_d  = WIN_L;
                        score_l_d = score_l_inc;
                        state_d   = WIN;
                    end else begin
                        pull_l_d = 1'b1;
                    end
                end else if (press_r && !press_l) begin
                    if (lights_i[0]) begin
                        winner_d  = WIN_R;
                        score_r_d = score_r_inc;
                        state_d   = WIN;
                    end else begin
                        pull_r_d = 1'b1;
                    end
                end
            end
            WIN: begin
                if (hold_q == HOLD_MAX) begin
                    hold_d  = '0;
                    state_d = (score_l_q == SCORE_MAX || score_r_q == SCORE_MAX) ? OVER : CLR;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            OVER: state_d = OVER;
            default: state_d = CLR;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= CLR;
            key_q     <= 1'b0;
            cpu_q     <= 1'b0;
            pull_l_q  <= 1'b0;
            pull_r_q  <= 1'b0;
            winner_q  <= WIN_NONE;
            score_l_q <= '0;
            score_r_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_player_i;
            cpu_q     <= cpu_lvl;
            pull_l_q  <= pull_l_d;
            pull_r_q  <= pull_r_d;
            winner_q  <= winner_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            hold_q    <= hold_d;
        end
    end

    assign pull_l_o      = pull_l_q;
    assign pull_r_o      = pull_r_q;
    assign round_reset_o = state_q == CLR;
    assign winner_o      = winner_q;
    assign score_l_o     = score_l_q;
    assign score_r_o     = score_r_q;
    assign game_over_o   = state_q == OVER;
endmodule

// File: tb/tb_tug_referee.sv
// tb_tug_referee: directed and random stimulus against a cycle-level behavioural model of the referee.
module tb_tug_referee;
    localparam int HOLD = 4;
    localparam int SMAX = 7;
    localparam int P_CLR = 0, P_PLAY = 1, P_WIN = 2, P_OVER = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key = 1'b0;
    logic [9:0] thresh = '0;
    logic [8:0] lights = 9'b000010000;
    logic       pull_l, pull_r, round_reset, game_over;
    logic [1:0] winner;
    logic [2:0] score_l, score_r;

    int total = 0;
    int bad = 0;

    int         m_phase, m_lfsr, m_hold_left, m_sl, m_sr;
    bit         m_kp, m_cp, m_pl, m_pr;
    logic [1:0] m_win;

    tug_referee dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .key_player_i  (key),
        .cpu_thresh_i  (thresh),
        .lights_i      (lights),
        .pull_l_o      (pull_l),
        .pull_r_o      (pull_r),
        .round_reset_o (round_reset),
        .winner_o      (winner),
        .score_l_o     (score_l),
        .score_r_o     (score_r),
        .game_over_o   (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_CLR; m_lfsr = 1023; m_hold_left = 0;
        m_sl = 0; m_sr = 0; m_kp = 0; m_cp = 0; m_pl = 0; m_pr = 0; m_win = 2'b00;
    endtask

    task automatic compare_all();
        chk("pull_l", pull_l, m_pl);
        chk("pull_r", pull_r, m_pr);
        chk("round_reset", round_reset, m_phase == P_CLR);
        chk("winner", winner, m_win);
        chk("score_l", score_l, m_sl[2:0]);
        chk("score_r", score_r, m_sr[2:0]);
        chk("game_over", game_over, m_phase == P_OVER);
    endtask

    task automatic tick();
        bit cl, pl, pr;
        @(posedge clk);
        if (reset) model_reset();
        else begin
            cl = m_lfsr < int'(thresh);
            pl = key && !m_kp;
            pr = cl && !m_cp;
            m_pl = 0;
            m_pr = 0;
            case (m_phase)
                P_CLR: begin m_phase = P_PLAY; m_win = 2'b00; end
                P_PLAY: if (pl && !pr) begin
                    if (lights[8]) begin
                        m_win = 2'b10; m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX;
                        m_phase = P_WIN; m_hold_left = HOLD;
                    end else m_pl = 1;
                end else if (pr && !pl) begin
                    if (lights[0]) begin
                        m_win = 2'b01; m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX;
                        m_phase = P_WIN; m_hold_left = HOLD;
                    end else m_pr = 1;
                end
                P_WIN: begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_phase = (m_sl == SMAX || m_sr == SMAX) ? P_OVER : P_CLR;
                end
                default: ;
            endcase
            m_kp = key;
            m_cp = cl;
            m_lfsr = ((m_lfsr * 2) % 1024) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
        end
        #1 compare_all();
    endtask

    initial begin
        model_reset();
        // 1: reset for two cycles, then one CLR cycle and PLAY
        #1 reset = 1'b1;
        #1 compare_all();
        tick();
        tick();
        reset = 1'b0;
        #1 chk("t1_rr_after_release", round_reset, 1'b1);
        tick();
        chk("t1_rr_play", round_reset, 1'b0);
        chk("t1_winner", winner, 2'b00);
        // 2: held key gives one pull_l, computer silent
        key = 1'b1;
        tick();
        chk("t2_pull_first", pull_l, 1'b1);
        tick();
        chk("t2_pull_held", pull_l, 1'b0);
        tick();
        chk("t2_pull_r", pull_r, 1'b0);
        key = 1'b0;
        tick();
        // 3: player wins from the leftmost light
        lights = 9'b100000000;
        key = 1'b1;
        tick();
        chk("t3_no_pull", pull_l, 1'b0);
        chk("t3_winner", winner, 2'b10);
        chk("t3_score", score_l, 3'd1);
        key = 1'b0;
        repeat (3) tick();
        chk("t3_hold_rr", round_reset, 1'b0);
        tick();
        chk("t3_clr_rr", round_reset, 1'b1);
        tick();
        chk("t3_play_rr", round_reset, 1'b0);
        chk("t3_play_winner", winner, 2'b00);
        lights = 9'b000010000;
        tick();
        // 4: simultaneous player and computer edges cancel
        while (m_lfsr == 1023) tick();
        key = 1'b1;
        thresh = 10'h3FF;
        tick();
        chk("t4_pull_l", pull_l, 1'b0);
        chk("t4_pull_r", pull_r, 1'b0);
        chk("t4_score_l", score_l, 3'd1);
        chk("t4_score_r", score_r, 3'd0);
        thresh = '0;
        key = 1'b0;
        repeat (2) tick();
        // random play against the model
        for (int i = 0; i < 400; i++) begin
            key = 1'($urandom_range(0, 1));
            thresh = 10'($urandom_range(0, 1023));
            lights = 9'(1 << $urandom_range(0, 8));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        key = 1'b0;
        thresh = '0;
        tick();
        // 5: seven player wins end the game
        lights = 9'b100000000;
        for (int w = 0; w < 7; w++) begin
            key = 1'b1;
            tick();
            key = 1'b0;
            repeat (6) tick();
        end
        chk("t5_score_l", score_l, 3'd7);
        chk("t5_game_over", game_over, 1'b1);
        chk("t5_winner", winner, 2'b10);
        lights = 9'b000010000;
        for (int i = 0; i < 20; i++) begin
            key = 1'(i % 2);
            thresh = 10'($urandom_range(0, 1023));
            tick();
            chk("t5_over_pull_l", pull_l, 1'b0);
            chk("t5_over_rr", round_reset, 1'b0);
        end
        // 6: async reset in the middle of the winner hold
        reset = 1'b1;
        tick();
        reset = 1'b0;
        thresh = '0;
        key = 1'b0;
        tick();
        lights = 9'b100000000;
        key = 1'b1;
        tick();
        key = 1'b0;
        tick();
        chk("t6_in_win", winner, 2'b10);
        #4 reset = 1'b1;
        #1;
        chk("t6_async_rr", round_reset, 1'b1);
        chk("t6_async_winner", winner, 2'b00);
        chk("t6_async_score", score_l, 3'd0);
        chk("t6_async_pull", pull_l, 1'b0);
        chk("t6_async_over", game_over, 1'b0);
        model_reset();
        tick();
        reset = 1'b0;
        lights = 9'b000010000;
        tick();
        chk("t6_replay_rr", round_reset, 1'b0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
